// File: rtl/pc_stack_sequencer.sv
// ---------------------------------------------------------------------------
// pc_stack_sequencer
//
// Program sequencer for the 8-bit microcontroller. It holds a single
// registered program counter and updates it once per enabled cycle according
// to the decoder's opcode. The opcodes are HOLD, INC, JUMP, relative BRANCH,
// SKIP, CALL and RET. CALL and RET use an internal return-address stack.
//
// A CALL on a full stack and a RET on an empty stack do not touch the stack.
// In both cases the PC simply advances by one, and a sticky error flag is
// raised.
//
// Parameters
//   ADDR_WIDTH   PC / return-address width
//   STACK_DEPTH  number of return-address entries (>= 2)
//   REL_WIDTH    width of the signed BRANCH offset (<= ADDR_WIDTH)
//   RESET_ADDR   PC value after reset
//
// Ports
//   clk          clock, rising edge
//   arst_n       asynchronous active-low reset
//   en           1 = execute op this cycle, 0 = stall (err_clr still acts)
//   op           3-bit opcode (see op_e)
//   pc_next      absolute target for JUMP / CALL
//   rel_off      signed two's-complement offset for BRANCH
//   err_clr      clears ovf_err / unf_err (a new error in the same cycle wins)
//   pc_out       current PC (registered)
//   ret_addr     top-of-stack entry, 0 when the stack is empty
//   depth        number of valid stack entries
//   stack_empty  depth == 0
//   stack_full   depth == STACK_DEPTH
//   ovf_err      sticky: CALL attempted while full
//   unf_err      sticky: RET attempted while empty
// ---------------------------------------------------------------------------
module pc_stack_sequencer #(
    parameter int unsigned              ADDR_WIDTH  = 12,
    parameter int unsigned              STACK_DEPTH = 8,
    parameter int unsigned              REL_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]    RESET_ADDR  = '0,
    localparam int unsigned             DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic [REL_WIDTH-1:0]  rel_off,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] ret_addr,
    output logic [DEPTH_W-1:0]    depth,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  ovf_err,
    output logic                  unf_err
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_JUMP   = 3'b010,
        OP_BRANCH = 3'b011,
        OP_SKIP   = 3'b100,
        OP_CALL   = 3'b101,
        OP_RET    = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DEPTH_W-1:0]    depth_q;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic                  ovf_q;
    logic                  unf_q;

    // -----------------------------------------------------------------------
    // Decoded / next-state signals
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic [ADDR_WIDTH-1:0] rel_ext;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      top_idx;
    logic                  is_empty;
    logic                  is_full;

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [DEPTH_W-1:0]    depth_d;
    logic                  push_en;
    logic                  ovf_set;
    logic                  unf_set;

    assign pc_plus1 = pc_q + ADDR_WIDTH'(1);

    // Sign-extending cast; it also covers REL_WIDTH == ADDR_WIDTH, where an
    // explicit replication of the sign bit would have zero width.
    assign rel_ext  = ADDR_WIDTH'($signed(rel_off));

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_W'(STACK_DEPTH));

    // The push slot is only used when the stack is not full, and the top
    // slot is only used when it is not empty. So both indices stay in range
    // whenever they are actually used.
    assign push_idx = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));

    // NOTE: every output of this block gets a default before the case
    // statement, so no path leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (en) begin
            unique case (op_e'(op))
                OP_INC:    pc_d = pc_plus1;
                OP_JUMP:   pc_d = pc_next;
                // The offset is relative to the current PC, not to PC+1.
                OP_BRANCH: pc_d = pc_q + rel_ext;
                OP_SKIP:   pc_d = pc_q + ADDR_WIDTH'(2);
                OP_CALL: begin
                    if (is_full) begin
                        pc_d    = pc_plus1;
                        ovf_set = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                        pc_d    = pc_next;
                    end
                end
                OP_RET: begin
                    if (is_empty) begin
                        pc_d    = pc_plus1;
                        unf_set = 1'b1;
                    end else begin
                        // The popped entry stays in the array. Only depth
                        // moves.
                        depth_d = depth_q - DEPTH_W'(1);
                        pc_d    = stack_q[top_idx];
                    end
                end
                OP_HOLD, OP_RSVD: ;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments.
    // That way every register samples the pre-edge values computed above,
    // regardless of the order in which the blocks are evaluated.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    // NOTE: the return-address array is cleared on reset on purpose. That
    // makes its contents after reset well defined. It also stops X from
    // stale entries from ever reaching pc_out through a later RET.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_en) begin
            stack_q[push_idx] <= pc_plus1;
        end
    end

    // Sticky error flags. A new error in the same cycle as err_clr wins.
    // err_clr is honoured even while stalled.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;

            if (unf_set)      unf_q <= 1'b1;
            else if (err_clr) unf_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pc_out      = pc_q;
    assign depth       = depth_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
    assign ret_addr    = is_empty ? '0 : stack_q[top_idx];

endmodule

// File: doc/pc_stack_sequencer.md
# pc_stack_sequencer

Parametrised program sequencer for the 8-bit microcontroller: it replaces the plain load/increment program counter with a single registered PC that also supports relative branches, skips, and subroutine CALL/RET backed by an internal hardware return-address stack. It sits between the instruction decoder, which issues one opcode per cycle, and the program-memory address port. Stack overflow and underflow are trapped with sticky flags and never corrupt the PC.

## Interface
- ADDR_WIDTH, 12, PC and return-address width in bits
- STACK_DEPTH, 8, number of return-address entries (≥2)
- REL_WIDTH, 8, width of signed relative branch offset (≤ADDR_WIDTH)
- RESET_ADDR, 0, PC value loaded on reset
- clk  input  1  clock, all state updates on rising edge
- arst_n  input  1  asynchronous, active-low reset
- en  input  1  1 = execute op this cycle; 0 = stall, hold PC and stack
- op  input  3  000 HOLD, 001 INC, 010 JUMP, 011 BRANCH, 100 SKIP, 101 CALL, 110 RET, 111 reserved (acts as HOLD)
- pc_next  input  ADDR_WIDTH  absolute target for JUMP/CALL
- rel_off  input  REL_WIDTH  signed two's-complement offset for BRANCH
- err_clr  input  1  clears ovf_err/unf_err; honoured regardless of en
- pc_out  output  ADDR_WIDTH  current PC, registered
- ret_addr  output  ADDR_WIDTH  top-of-stack entry; 0 when empty
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_empty  output  1  depth == 0
- stack_full  output  1  depth == STACK_DEPTH
- ovf_err  output  1  sticky: CALL attempted while full
- unf_err  output  1  sticky: RET attempted while empty

## Operation
- Reset (async assert, sync release on clk): pc_out=RESET_ADDR, depth=0, all stack entries=0, ret_addr=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0.
- All PC arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent, with no flag.
- When en=1, per op:
  - HOLD/111: no change.
  - INC: pc ← pc+1.
  - JUMP: pc ← pc_next.
  - BRANCH: pc ← pc + sign_extend(rel_off). Relative to the current pc_out, not pc+1.
  - SKIP: pc ← pc+2.
  - CALL, not full: stack[depth] ← pc+1; depth+1; pc ← pc_next.
  - CALL, full: no push; pc ← pc+1; ovf_err ← 1.
  - RET, not empty: pc ← stack[depth-1]; depth−1. The popped entry is not cleared.
  - RET, empty: pc ← pc+1; unf_err ← 1.
- en=0: pc, stack and depth hold. err_clr still acts.
- err_clr and a new error in the same cycle: set wins, so the flag stays 1. err_clr clears both flags otherwise.
- ret_addr = stack[depth-1] when depth>0, else 0. It is combinational from registered state.
- stack_full/stack_empty are decoded combinationally from depth.

## Timing
- Single cycle: op sampled at rising edge; pc_out, depth and flags reflect it after that same edge, with no added latency.
- Back-to-back CALL/RET every cycle is supported. RET immediately after CALL returns to call-site+1.
- Reset asserted mid-operation immediately forces the reset values. The first op is accepted on the first rising edge with arst_n=1.
- No combinational path from any input to pc_out, depth or the error flags.

## Test plan
- Reset/INC/wrap: with ADDR_WIDTH=12 and RESET_ADDR=0, check pc_out=0 after reset. JUMP pc_next=0xFFE, then INC ×3 -> pc_out 0xFFF, 0x000, 0x001.
- BRANCH sign: pc=0x100. BRANCH rel_off=0xF0 (−16) -> 0x0F0. BRANCH rel_off=0x10 -> 0x100. SKIP -> 0x102.
- Nested CALL/RET: pc=0x010. CALL 0x200 -> pc=0x200, depth=1, ret_addr=0x011. CALL 0x300 -> depth=2, ret_addr=0x201. RET -> pc=0x201. RET -> pc=0x011, depth=0, stack_empty=1.
- Overflow: STACK_DEPTH=8. Issue 8 CALLs -> stack_full=1. A 9th CALL at pc=0x050 -> pc=0x051, depth stays 8, ovf_err=1. err_clr -> ovf_err=0.
- Underflow and set-wins: empty stack, pc=0x020. RET with err_clr=1 the same cycle -> pc=0x021, unf_err=1.
- Stall and reset mid-op: depth=3. en=0 with op=CALL for 4 cycles -> pc and depth unchanged. Assert arst_n=0 mid-cycle -> pc_out=RESET_ADDR, depth=0, flags 0 immediately.
